// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, credit-limited imem requests, decode FIFO
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);
  // Counter width covers 0..DEPTH; pointer width indexes DEPTH slots.
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = CW1'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic            started;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;

  // Addresses of requests still waiting for their response, in issue order.
  logic [XLEN-1:0] pcq [DEPTH];
  logic [PW-1:0]   q_wr;
  logic [PW-1:0]   q_rd;

  // Decode-side buffer of {pc, instr} pairs.
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [PW-1:0]   f_wr;
  logic [PW-1:0]   f_rd;

  logic            pop;
  logic            req_fire;
  logic            rsp_keep;
  logic [CW:0]     credit_used;

  // Circular pointer advance that works for non-power-of-two depths.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign pop            = if_valid & if_ready;
  // A slot freed by this cycle's pop can already be reused by a new request.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = started & ~pc_src & (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  // Responses belonging to a squashed path (or arriving in the redirect cycle) are dropped.
  assign rsp_keep       = imem_rsp_valid & ~pc_src & (drop_cnt == '0);

  assign if_valid = (count != '0);
  assign if_pc    = fifo_pc[f_rd];
  assign if_instr = fifo_instr[f_rd];

  // Program counter: reload on redirect, advance one word per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      started <= 1'b1;
      if (pc_src) begin
        pc_q <= {pc_target[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  // In-flight bookkeeping: PC queue, outstanding count and stale-response discard count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        pcq[q_wr] <= pc_q;
        q_wr      <= bump(q_wr);
      end
      if (imem_rsp_valid) begin
        q_rd <= bump(q_rd);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (pc_src) begin
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Instruction buffer: pair each kept response with its queued PC; flush on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      f_wr  <= '0;
      f_rd  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (pc_src) begin
      count <= '0;
      f_wr  <= '0;
      f_rd  <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_pc[f_wr]    <= pcq[q_rd];
        fifo_instr[f_wr] <= imem_rsp_data;
        f_wr             <= bump(f_wr);
      end
      if (pop) begin
        f_rd <= bump(f_rd);
      end
      count <= count + CW'(rsp_keep) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a program-order model
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  int          fires = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] last_fire_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the model, then drive memory responses.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
    end else begin
      if (pc_src) begin
        chk("redir_no_req", imem_req_valid, 0);
        exp_pc     = {pc_target[31:2], 2'b00};
        exp_req    = exp_pc;
        stall_prev = 1'b0;
      end else begin
        if (imem_req_valid) begin
          chk("req_addr", imem_req_addr, exp_req);
          if (stall_prev) chk("stall_addr_stable", imem_req_addr, stall_addr);
          if (imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            exp_req        = exp_req + 32'd4;
            fires++;
            last_fire_addr = imem_req_addr;
          end
        end
        stall_prev = imem_req_valid & ~imem_req_ready;
        stall_addr = imem_req_addr;
        if (if_valid && if_ready) begin
          chk("if_pc", if_pc, exp_pc);
          chk("if_instr", if_instr, mem_word(exp_pc));
          exp_pc      = exp_pc + 32'd4;
          last_pop_pc = if_pc;
          pops++;
        end
      end
      chk("inflight_le_depth", mq_addr.size() <= DEPTH, 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Reset the DUT and the memory/model together; memory forgets pre-reset requests.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    pc_src         = 1'b0;
    imem_rsp_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    exp_pc     = RESET_PC;
    exp_req    = RESET_PC;
    stall_prev = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int          seen;
    int          bubbles;
    int          p0;
    int          f0;
    int          found;
    logic [31:0] sa;
    logic [31:0] tgt;

    // Reset and release
    do_reset(3);
    #2 chk("rel_before_start", imem_req_valid, 0);
    tick();
    #2;
    chk("rel_req_valid", imem_req_valid, 1);
    chk("rel_req_addr", imem_req_addr, RESET_PC);

    // Streaming fetch with L=1
    lat = 1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    seen = 0;
    bubbles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      #2;
      if (if_valid) seen = 1;
      else if (seen != 0) bubbles++;
    end
    chk("stream_started", seen, 1);
    chk("stream_bubbles", bubbles, 0);

    // Backpressure from decode
    if_ready = 1'b0;
    repeat (5) tick();
    #2;
    chk("bp_if_valid", if_valid, 1);
    chk("bp_req_blocked", imem_req_valid, 0);
    if_ready = 1'b1;
    p0 = pops;
    repeat (10) tick();
    chk("bp_resume", (pops - p0) >= 8, 1);

    // Redirect with two requests in flight at L=3
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      #2;
      if (mq_addr.size() + int'(imem_rsp_valid) == 2) found = 1;
    end
    chk("rd_two_inflight", found, 1);
    pc_src = 1'b1;
    pc_target = 32'h0000_0103;
    p0 = pops;
    tick();
    pc_src = 1'b0;
    for (int i = 0; i < 30 && pops == p0; i++) tick();
    chk("rd_delivered", pops > p0, 1);
    chk("rd_first_pc", last_pop_pc, 32'h0000_0100);

    // Memory stall, then redirect
    lat = 1;
    imem_req_ready = 1'b0;
    tick();
    #2;
    sa = imem_req_addr;
    chk("stall_valid0", imem_req_valid, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      #2;
      chk("stall_valid", imem_req_valid, 1);
      chk("stall_addr", imem_req_addr, sa);
    end
    tgt = 32'h0000_2000 + {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
    pc_src = 1'b1;
    pc_target = tgt;
    tick();
    pc_src = 1'b0;
    imem_req_ready = 1'b1;
    f0 = fires;
    for (int i = 0; i < 10 && fires == f0; i++) tick();
    chk("stall_redir_fired", fires > f0, 1);
    chk("stall_redir_addr", last_fire_addr, {tgt[31:2], 2'b00});

    // Reset with traffic in flight
    lat = 3;
    if_ready = 1'b0;
    repeat (4) tick();
    do_reset(2);
    lat = 1;
    if_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10 && pops == p0; i++) tick();
    chk("rst_mid_delivered", pops > p0, 1);
    chk("rst_mid_first_pc", last_pop_pc, RESET_PC);

    // Randomized traffic with redirects and variable latency
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        pc_src    = 1'b1;
        pc_target = $urandom;
      end else begin
        pc_src = 1'b0;
      end
      tick();
    end
    pc_src = 1'b0;
    chk("rand_progress", (pops - p0) > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
